// File: rtl/max7219_receiver.sv
// max7219_receiver: MAX7219 register-file emulator on an SPI mode-0 slave port.
// All SPI inputs are resynchronised into clk; words are committed on the Cs rise.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// WAIT_IDLE   | after reset; ignore the bus until Cs is genuinely seen high
// IDLE        | bus idle, waiting for a Cs falling edge
// SHIFT       | frame active; shift Mosi on every Sclk rise
// LATCH       | single cycle; commit a 16-bit word or flag a short frame

module max7219_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic        Cs,
    input  logic        Sclk,
    input  logic        Mosi,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        word_valid,
    output logic [3:0]  word_addr,
    output logic [7:0]  word_data,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_SHIFT     = 2'd2,
        S_LATCH     = 2'd3
    } state_t;

    // Cycles needed after reset release before the Cs chain reflects the real pin.
    localparam logic [2:0] FLUSH_INIT = 3'(SYNC_STAGES + 2);
    localparam logic [4:0] FULL_WORD  = 5'd16;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sclk_d;
    logic                   r_mosi_d;
    logic                   r_cs_rise;
    logic                   r_cs_fall;
    logic                   r_sclk_rise;
    logic [2:0]             r_flush_cnt;

    logic                   w_cs_s;
    logic                   w_sclk_s;
    logic                   w_mosi_s;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_clr_cnt;
    logic                   w_shift;
    logic                   w_commit;
    logic                   w_err;

    // Only the low 12 bits of the last 16 shifted in are ever decoded (the top
    // nibble is ignored), so only those are kept.
    logic [11:0]            r_shreg;
    logic [4:0]             r_bit_cnt;
    logic [3:0]             w_addr;
    logic [7:0]             w_data;

    logic [63:0]            r_digits;
    logic [7:0]             r_decode_mode;
    logic [3:0]             r_intensity;
    logic [2:0]             r_scan_limit;
    logic                   r_shutdown_n;
    logic                   r_display_test;
    logic                   r_word_valid;
    logic [3:0]             r_word_addr;
    logic [7:0]             r_word_data;
    logic                   r_frame_err;

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_addr   = r_shreg[11:8];
    assign w_data   = r_shreg[7:0];

    // Input synchronisers plus registered edge pulses; Mosi gets one extra
    // flop so it stays aligned with the registered Sclk rise pulse.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
            r_mosi_d    <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_sclk_rise <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], Cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], Sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], Mosi};
            r_cs_d      <= w_cs_s;
            r_sclk_d    <= w_sclk_s;
            r_mosi_d    <= w_mosi_s;
            r_cs_rise   <= w_cs_s & ~r_cs_d;
            r_cs_fall   <= ~w_cs_s & r_cs_d;
            r_sclk_rise <= w_sclk_s & ~r_sclk_d;
        end
    end

    // Down-counter that masks the reset value (high) still sitting in the Cs chain.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_flush_cnt <= FLUSH_INIT;
        end else if (r_flush_cnt != 3'd0) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and datapath controls; a Cs rise beats a same-cycle Sclk rise.
    always_comb begin
        w_next    = r_state;
        w_clr_cnt = 1'b0;
        w_shift   = 1'b0;
        w_commit  = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            S_WAIT_IDLE: begin
                if (r_flush_cnt == 3'd0 && r_cs_d) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (r_cs_fall) begin
                    w_clr_cnt = 1'b1;
                    w_next    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cs_rise) begin
                    w_next = S_LATCH;
                end else if (r_sclk_rise) begin
                    w_shift = 1'b1;
                end
            end
            S_LATCH: begin
                if (r_bit_cnt == FULL_WORD) begin
                    w_commit = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
                if (r_cs_fall) begin
                    w_clr_cnt = 1'b1;
                    w_next    = S_SHIFT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_WAIT_IDLE;
        endcase
    end

    // Shift register and saturating bit counter.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_clr_cnt) begin
                r_bit_cnt <= '0;
            end else if (w_shift && r_bit_cnt != FULL_WORD) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_shift) begin
                r_shreg <= {r_shreg[10:0], r_mosi_d};
            end
        end
    end

    // Register file commit and the one-cycle status pulses.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_digits       <= '0;
            r_decode_mode  <= '0;
            r_intensity    <= '0;
            r_scan_limit   <= '0;
            r_shutdown_n   <= 1'b0;
            r_display_test <= 1'b0;
            r_word_valid   <= 1'b0;
            r_word_addr    <= '0;
            r_word_data    <= '0;
            r_frame_err    <= 1'b0;
        end else begin
            r_word_valid <= w_commit;
            r_frame_err  <= w_err;
            if (w_commit) begin
                r_word_addr <= w_addr;
                r_word_data <= w_data;
                case (w_addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8:
                        r_digits[{w_addr[2:0] - 3'd1, 3'b000} +: 8] <= w_data;
                    4'h9: r_decode_mode  <= w_data;
                    4'hA: r_intensity    <= w_data[3:0];
                    4'hB: r_scan_limit   <= w_data[2:0];
                    4'hC: r_shutdown_n   <= w_data[0];
                    4'hF: r_display_test <= w_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign digits       = r_digits;
    assign decode_mode  = r_decode_mode;
    assign intensity    = r_intensity;
    assign scan_limit   = r_scan_limit;
    assign shutdown_n   = r_shutdown_n;
    assign display_test = r_display_test;
    assign word_valid   = r_word_valid;
    assign word_addr    = r_word_addr;
    assign word_data    = r_word_data;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_max7219_receiver.sv
// Bench for max7219_receiver: table of SPI frames with a pulse scoreboard,
// plus hand-written latency and reset-mid-frame sequences.

module tb_max7219_receiver;

    logic        clk = 1'b0;
    logic        res;
    logic        Cs;
    logic        Sclk;
    logic        Mosi;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n;
    logic        display_test;
    logic        word_valid;
    logic [3:0]  word_addr;
    logic [7:0]  word_data;
    logic        frame_err;

    typedef struct {
        logic       err;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] val;
        int          nbits;
        logic        err;
        logic [3:0]  addr;   // word_addr expected after the frame
        logic [7:0]  data;   // word_data expected after the frame
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[12];

    int n_vec   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int n_ferr  = 0;

    max7219_receiver #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .res          (res),
        .Cs           (Cs),
        .Sclk         (Sclk),
        .Mosi         (Mosi),
        .digits       (digits),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test),
        .word_valid   (word_valid),
        .word_addr    (word_addr),
        .word_data    (word_data),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            Mosi = val[i];
            Sclk = 1'b0;
            tick(2);
            Sclk = 1'b1;
            tick(2);
        end
        Sclk = 1'b0;
        tick(2);
    endtask

    task automatic frame(input logic [31:0] val, input int nbits);
        Cs = 1'b0;
        tick(2);
        send_bits(val, nbits);
        Cs = 1'b1;
        tick(16);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (word_valid || frame_err) begin
                if (word_valid) n_valid++;
                if (frame_err)  n_ferr++;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: word_valid=%0b frame_err=%0b, none expected",
                             word_valid, frame_err);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_kind", 64'({word_valid, frame_err}), e.err ? 64'h1 : 64'h2);
                    if (!e.err) begin
                        chk("sb_word", 64'({word_addr, word_data}), 64'({e.addr, e.data}));
                    end
                end
            end
        end
    endtask

    initial begin
        logic [5:0] lat;
        int         v0;
        int         f0;
        exp_t       e;

        vt[0]  = '{32'h0C01,  16, 1'b0, 4'hC, 8'h01};
        vt[1]  = '{32'h0A05,  16, 1'b0, 4'hA, 8'h05};
        vt[2]  = '{32'h0B05,  16, 1'b0, 4'hB, 8'h05};
        vt[3]  = '{32'h093F,  16, 1'b0, 4'h9, 8'h3F};
        vt[4]  = '{32'h0107,  16, 1'b0, 4'h1, 8'h07};
        vt[5]  = '{32'h0283,  16, 1'b0, 4'h2, 8'h83};
        vt[6]  = '{32'h0612,  16, 1'b0, 4'h6, 8'h12};
        vt[7]  = '{32'h00C0,  12, 1'b1, 4'h6, 8'h12};   // short: first 12 bits of 0x0C01
        vt[8]  = '{32'hF0A07, 20, 1'b0, 4'hA, 8'h07};   // long: last 16 bits kept
        vt[9]  = '{32'h0D55,  16, 1'b0, 4'hD, 8'h55};   // ignored address
        vt[10] = '{32'h3BFF,  16, 1'b0, 4'hB, 8'hFF};   // top nibble ignored
        vt[11] = '{32'h0000,  16, 1'b0, 4'h0, 8'h00};   // no-op

        res  = 1'b0;
        Cs   = 1'b1;
        Sclk = 1'b0;
        Mosi = 1'b0;
        fork
            monitor();
        join_none
        tick(3);

        chk("rst_digits",   digits, 64'h0);
        chk("rst_decode",   64'(decode_mode), 64'h0);
        chk("rst_int",      64'(intensity), 64'h0);
        chk("rst_scan",     64'(scan_limit), 64'h0);
        chk("rst_flags",    64'({shutdown_n, display_test, word_valid, frame_err}), 64'h0);
        chk("rst_word",     64'({word_addr, word_data}), 64'h0);

        res = 1'b1;
        tick(10);

        for (int i = 0; i < 12; i++) begin
            sb_q.push_back('{vt[i].err, vt[i].addr, vt[i].data});
            frame(vt[i].val, vt[i].nbits);
            chk("sb_drained", 64'(sb_q.size()), 64'h0);
            chk("word_hold",  64'({word_addr, word_data}), 64'({vt[i].addr, vt[i].data}));
            if (i == 3) begin
                chk("pu_shutdown", 64'(shutdown_n), 64'h1);
                chk("pu_int",      64'(intensity), 64'h5);
                chk("pu_scan",     64'(scan_limit), 64'h5);
                chk("pu_decode",   64'(decode_mode), 64'h3F);
                chk("pu_valids",   64'(n_valid), 64'h4);
            end
        end

        chk("tbl_shutdown", 64'(shutdown_n), 64'h1);
        chk("tbl_int",      64'(intensity), 64'h7);
        chk("tbl_scan",     64'(scan_limit), 64'h7);
        chk("tbl_decode",   64'(decode_mode), 64'h3F);
        chk("tbl_test",     64'(display_test), 64'h0);
        chk("tbl_digits",   digits, 64'h0000_1200_0000_8307);
        chk("tbl_ferr",     64'(n_ferr), 64'h1);

        // Latency: Cs goes high just after an edge, so the next edge N samples it.
        sb_q.push_back('{1'b0, 4'h1, 8'h55});
        Cs = 1'b0;
        tick(2);
        send_bits(32'h0155, 16);
        Cs = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            lat[k] = word_valid;
        end
        chk("latency", 64'(lat), 64'h10);
        tick(16);
        chk("lat_digit0", 64'(digits[7:0]), 64'h55);

        // Reset asserted mid-frame, released with Cs still low.
        v0 = n_valid;
        f0 = n_ferr;
        Cs = 1'b0;
        tick(2);
        send_bits(32'h0F, 8);
        res = 1'b0;
        tick(2);
        chk("mid_rst_digits", digits, 64'h0);
        chk("mid_rst_shdn",   64'(shutdown_n), 64'h0);
        res = 1'b1;
        tick(2);
        send_bits(32'h01, 8);
        Cs = 1'b1;
        tick(16);
        chk("mid_no_valid", 64'(n_valid - v0), 64'h0);
        chk("mid_no_ferr",  64'(n_ferr - f0), 64'h0);

        e = '{1'b0, 4'hF, 8'h01};
        sb_q.push_back(e);
        frame(32'h0F01, 16);
        chk("post_rst_test", 64'(display_test), 64'h1);
        chk("post_rst_int",  64'(intensity), 64'h0);

        for (int k = 0; k < 50 && sb_q.size() != 0; k++) tick(1);
        chk("final_drain", 64'(sb_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
